dmem_bus_adapter: RTL
=====================

# dmem_bus_adapter

Testbench-support adapter that sits directly upstream of the byte-write single-port RAM model. It turns a core-side valid/ready load/store request channel into the RAM's byte-enable/word-address/data signals. It returns aligned, sign- or zero-extended load data on a valid/ready response channel. It lets the core's data port and any bus master in the bench drive the RAM without knowing its lane layout or its 1-cycle read latency.

## Interface
- ADDR_WIDTH, 32, byte-address width; RAM side and request side share it.
- STALL_SEED, 16'hACE1, LFSR seed for stall injection; 0 is replaced by 16'hACE1.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  adapter accepts the request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads; ignored for word and stores.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load data, aligned and extended; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal-size request.
- ram_we  out  4  byte write enables to the RAM.
- ram_addr  out  ADDR_WIDTH  RAM byte address, bits [1:0] always 0.
- ram_di  out  32  RAM write data, lane-replicated.
- ram_dout  in  32  RAM read data, valid one cycle after the address is sampled.

## Operation
- FSM with states IDLE, LOAD, RESP. Reset state is IDLE.
- req_ready = (state==IDLE) && !rst && !stall.
- A request is accepted on a rising edge where req_valid && req_ready.
- Error condition: req_size==11, half with addr[0]=1, or word with addr[1:0]!=0.
  - An erroring request produces no RAM write.
  - IDLE→RESP with rsp_err=1 and rsp_rdata=0.
- Accepted store: ram_we is asserted combinationally in the accept cycle only.
  - byte: ram_we = 1<<addr[1:0], ram_di = {4{wdata[7:0]}}.
  - half: ram_we = addr[1] ? 1100 : 0011, ram_di = {2{wdata[15:0]}}.
  - word: ram_we = 1111, ram_di = wdata.
  - Transition IDLE→RESP with rsp_err=0 and rsp_rdata=0.
- Accepted aligned load: ram_we=0000 and IDLE→LOAD.
  - The lane selector (addr[1:0]), size and unsigned flag are latched.
- LOAD→RESP unconditionally.
  - On that edge, ram_dout is lane-extracted using the latched lane, extended, and registered into rsp_rdata.
- RESP: rsp_valid=1. RESP→IDLE on a rising edge where rsp_ready=1.
  - rsp_rdata and rsp_err hold stable while rsp_ready=0.
- ram_addr in IDLE is {req_addr[ADDR_WIDTH-1:2],2'b00}. In other states it is the latched word address.
- ram_we is 0000 in every state except the store-accept cycle.

## Timing
- Reset values: rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0 while rst is high, ram_we 0000, state IDLE, LFSR = STALL_SEED.
- Store and error latency: rsp_valid rises 1 cycle after the accept edge.
- Load latency: rsp_valid rises 2 cycles after the accept edge. The RAM samples the address at the accept edge, and the adapter captures ram_dout at the following edge.
- Throughput: at most one request per 2 cycles (store) or 3 cycles (load), given rsp_ready=1.
- Reset asserted in LOAD or RESP: rsp_valid drops to 0 immediately, the pending response is discarded, and no RAM write is issued.
- No request is accepted while a response is outstanding.

## Configuration
- DMEM_STALL_EN defined:
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 advances every cycle.
  - stall = (lfsr[1:0]==00).
  - This deasserts req_ready in IDLE for that cycle only.
- DMEM_STALL_EN undefined: stall=0 and no LFSR logic is present.

## Structure
- Package dmem_pkg holds:
  - the size constants SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - the state enum;
  - the default LFSR seed.
- Sub-module dmem_load_align: combinational lane extraction and sign/zero extension. Inputs are word, lane, size and unsigned; output is 32-bit data.

## Test plan
- Store word 0xDEADBEEF at 0x10: ram_we=1111, ram_addr=0x10, rsp_valid 1 cycle later with rsp_err=0. A subsequent word load from 0x10 returns 0xDEADBEEF 2 cycles after accept.
- Store byte 0x80 at 0x13: ram_we=1000, ram_di=0x80808080. A signed byte load from 0x13 returns 0xFFFFFF80; an unsigned load returns 0x00000080.
- Store half 0x8001 at 0x22: ram_we=1100. A signed half load returns 0xFFFF8001. A half load at 0x21 returns rsp_err=1 and rdata=0. A half store at 0x21 shows ram_we=0000 throughout.
- Load with rsp_ready held low for 5 cycles: rsp_valid stays 1, rsp_rdata stays constant, req_ready stays 0; exactly one response is taken.
- rst pulsed while in LOAD: rsp_valid=0 immediately, the next request is accepted normally, and RAM contents are unchanged.
- With DMEM_STALL_EN and seed 0xACE1: 1000 random aligned and misaligned requests all match a scoreboard, and req_ready is observed low in IDLE at least once.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory bus adapter.
//   Size encodings, adapter state enum, default stall-LFSR seed and the
//   request legality helper used by the adapter.
package dmem_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam logic [15:0] DEFAULT_STALL_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RESP = 2'd2
   } state_e;

   // Illegal size, or half/word not naturally aligned.
   function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = addr_lo[0];
         SIZE_W:  bad = |addr_lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: extracts the addressed byte/half/word from a RAM word and
// sign- or zero-extends it to 32 bits.
//   i_word     RAM read word
//   i_lane     byte offset within the word (addr[1:0])
//   i_size     SIZE_B / SIZE_H / SIZE_W
//   i_unsigned 1 = zero-extend, 0 = sign-extend
//   o_data     aligned, extended load data (0 for illegal size)
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection
   always_comb begin
      w_byte = i_word[7:0];
      case (i_lane)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
   end

   // Extension
   always_comb begin
      o_data = 32'h0;
      case (i_size)
         SIZE_B:  o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         SIZE_H:  o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
         SIZE_W:  o_data = i_word;
         default: o_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/dmem_bus_adapter.sv
// dmem_bus_adapter: valid/ready load/store channel to byte-write RAM adapter.
//   Stores issue lane-replicated data with byte enables in the accept cycle;
//   loads account for the RAM's 1-cycle read latency and return aligned,
//   extended data. Misaligned / illegal-size requests answer with rsp_err.
// Ports:
//   clk, rst                        clock, async active-high reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr, req_size,
//   req_unsigned, req_wdata         request payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              response payload
//   ram_we, ram_addr, ram_di        RAM write enables, word address, data
//   ram_dout                        RAM read data (1-cycle latency)
// Build option: define DMEM_STALL_EN to inject pseudo-random req_ready stalls
//   from a 16-bit LFSR seeded with STALL_SEED.
module dmem_bus_adapter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [15:0] STALL_SEED = DEFAULT_STALL_SEED
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_di,
   input  logic [31:0]           ram_dout
);

   localparam int unsigned WORD_AW = ADDR_WIDTH - 2;

   state_e               r_state;
   state_e               w_next;
   logic [WORD_AW-1:0]   r_word_addr;
   logic [1:0]           r_lane;
   logic [1:0]           r_size;
   logic                 r_unsigned;
   logic [31:0]          r_rdata;
   logic                 r_err;

   logic                 w_stall;
   logic                 w_err;
   logic                 w_accept;
   logic [3:0]           w_store_we;
   logic [31:0]          w_load_data;

`ifdef DMEM_STALL_EN
   localparam logic [15:0] LP_SEED = (STALL_SEED == 16'h0) ? DEFAULT_STALL_SEED : STALL_SEED;

   logic [15:0] r_lfsr;

   // Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_lfsr <= LP_SEED;
      else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
   assign w_stall = 1'b0;
`endif

   assign w_err     = req_misaligned(req_size, req_addr[1:0]);
   assign req_ready = (r_state == IDLE) && !rst && !w_stall;
   assign w_accept  = req_valid && req_ready;

   // Store byte enables and lane-replicated write data
   always_comb begin
      w_store_we = 4'b0000;
      ram_di     = req_wdata;
      case (req_size)
         SIZE_B: begin
            w_store_we = 4'(4'b0001 << req_addr[1:0]);
            ram_di     = {4{req_wdata[7:0]}};
         end
         SIZE_H: begin
            w_store_we = req_addr[1] ? 4'b1100 : 4'b0011;
            ram_di     = {2{req_wdata[15:0]}};
         end
         SIZE_W: begin
            w_store_we = 4'b1111;
            ram_di     = req_wdata;
         end
         default: w_store_we = 4'b0000;
      endcase
   end

   // Only a legal store in its accept cycle writes the RAM
   assign ram_we   = (w_accept && req_we && !w_err) ? w_store_we : 4'b0000;
   // IDLE presents the live address so the RAM samples it at the accept edge
   assign ram_addr = (r_state == IDLE) ? {req_addr[ADDR_WIDTH-1:2], 2'b00}
                                       : {r_word_addr, 2'b00};

   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = (w_err || req_we) ? RESP : LOAD;
         end
         LOAD:    w_next = RESP;
         RESP: begin
            if (rsp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   dmem_load_align u_align (
      .i_word     (ram_dout),
      .i_lane     (r_lane),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_data     (w_load_data)
   );

   // Request capture and response data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word_addr <= '0;
         r_lane      <= 2'b00;
         r_size      <= SIZE_B;
         r_unsigned  <= 1'b0;
         r_rdata     <= 32'h0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_word_addr <= req_addr[ADDR_WIDTH-1:2];
            r_lane      <= req_addr[1:0];
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_rdata     <= 32'h0;
            r_err       <= w_err;
         end
         if (r_state == LOAD) r_rdata <= w_load_data;
      end
   end

endmodule
